ula_chain_sequencer: RTL and testbench

Multi-cycle controller that runs operations wider than 8 bits through the team's combinational 8-bit ALU. It sits on the ALU's input side and drives `a`, `b`, `s`, `m` and `c_in`. It consumes `f`, `c_out`, `a_eq_b` and `overflow`, processing one byte slice per cycle, LSB first. Carry is chained between slices. Commands arrive and results leave over valid/ready handshakes, so a CPU-style datapath can issue N-byte ALU operations.

---
 rtl/ula_chain_sequencer.sv | 153 +++++++++++++++
 tb/tb_ula_chain_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_chain_sequencer.sv
// Runs NBYTES-wide operations through an external combinational 8-bit ALU,
// one byte slice per cycle (LSB first), chaining carry between slices.
module ula_chain_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [8*NBYTES-1:0]   cmd_a,
    input  logic [8*NBYTES-1:0]   cmd_b,
    input  logic [3:0]            cmd_s,
    input  logic                  cmd_m,
    input  logic                  cmd_c_in,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [3:0]            alu_s,
    output logic                  alu_m,
    output logic                  alu_c_in,
    input  logic [7:0]            alu_f,
    input  logic                  alu_c_out,
    input  logic                  alu_a_eq_b,
    input  logic                  alu_overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_f,
    output logic                  rsp_c_out,
    output logic                  rsp_a_eq_b,
    output logic                  rsp_overflow,
    output logic                  rsp_zero
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and rsp_* hold steady while rsp_valid waits for rsp_ready.

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  idx;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [3:0]     s_reg;
    logic           m_reg;
    logic           cin_reg;
    logic [W-1:0]   res_reg;
    logic           carry_reg;
    logic           eq_reg;
    logic           ovf_reg;
    logic           zero_reg;
    logic [7:0]     a_slice;
    logic [7:0]     b_slice;
    logic           accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
            cin_reg   <= 1'b0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            eq_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg    <= cmd_a;
                b_reg    <= cmd_b;
                s_reg    <= cmd_s;
                m_reg    <= cmd_m;
                cin_reg  <= cmd_c_in;
                idx      <= '0;
                res_reg  <= '0;
                eq_reg   <= 1'b1;
                zero_reg <= 1'b1;
            end else if (state == EXEC) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx == i[IW-1:0]) res_reg[8*i +: 8] <= alu_f;
                end
                carry_reg <= alu_c_out;
                eq_reg    <= eq_reg & alu_a_eq_b;
                // Each byte is written exactly once, so zero can accumulate per slice.
                zero_reg  <= zero_reg & (alu_f == 8'h00);
                if (idx == LAST) ovf_reg <= alu_overflow;
                else             idx     <= idx + IW'(1);
            end
        end
    end

    always_comb begin
        a_slice = 8'h00;
        b_slice = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == i[IW-1:0]) begin
                a_slice = a_reg[8*i +: 8];
                b_slice = b_reg[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_s     = 4'h0;
        alu_m     = 1'b0;
        alu_c_in  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid) state_nx = EXEC;
            end
            EXEC: begin
                alu_a    = a_slice;
                alu_b    = b_slice;
                alu_s    = s_reg;
                alu_m    = m_reg;
                // Logic mode has no inter-slice carry: every slice sees the command carry.
                alu_c_in = (idx == '0 || m_reg) ? cin_reg : carry_reg;
                if (idx == LAST) state_nx = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_f        = res_reg;
    assign rsp_c_out    = carry_reg;
    assign rsp_a_eq_b   = eq_reg;
    assign rsp_overflow = ovf_reg;
    assign rsp_zero     = zero_reg;

endmodule

// File: tb/tb_ula_chain_sequencer.sv
// Bench for ula_chain_sequencer: 2-byte and 1-byte instances, each driving a
// 74181-style 8-bit ALU model (active-low carry, A=B when F is all ones).
module tb_ula_chain_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 2-byte instance
    logic        cmd_valid2, cmd_ready2, cmd_m2, cmd_c_in2;
    logic [15:0] cmd_a2, cmd_b2;
    logic [3:0]  cmd_s2;
    logic [7:0]  alu_a2, alu_b2, alu_f2;
    logic [3:0]  alu_s2;
    logic        alu_m2, alu_c_in2, alu_co2, alu_eq2, alu_ov2;
    logic        rsp_valid2, rsp_ready2, rsp_co2, rsp_eq2, rsp_ov2, rsp_zero2;
    logic [15:0] rsp_f2;

    // 1-byte instance
    logic        cmd_valid1, cmd_ready1, cmd_m1, cmd_c_in1;
    logic [7:0]  cmd_a1, cmd_b1;
    logic [3:0]  cmd_s1;
    logic [7:0]  alu_a1, alu_b1, alu_f1;
    logic [3:0]  alu_s1;
    logic        alu_m1, alu_c_in1, alu_co1, alu_eq1, alu_ov1;
    logic        rsp_valid1, rsp_ready1, rsp_co1, rsp_eq1, rsp_ov1, rsp_zero1;
    logic [7:0]  rsp_f1;

    logic [19:0] exp_q2[$];
    logic [11:0] exp_q1[$];

    // Returns {overflow, a_eq_b, c_out, f}; carry in/out are active low.
    function automatic logic [10:0] alu181(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s, input logic m, input logic cn);
        logic [7:0] f, q;
        logic [8:0] sum;
        logic       co, ov;
        f = 8'h00; q = 8'h00; co = 1'b1; ov = 1'b0; sum = '0;
        if (m) begin
            case (s)
                4'b0000: f = ~a;
                4'b0001: f = ~(a | b);
                4'b0010: f = ~a & b;
                4'b0011: f = 8'h00;
                4'b0100: f = ~(a & b);
                4'b0101: f = ~b;
                4'b0110: f = a ^ b;
                4'b0111: f = a & ~b;
                4'b1000: f = ~a | b;
                4'b1001: f = ~(a ^ b);
                4'b1010: f = b;
                4'b1011: f = a & b;
                4'b1100: f = 8'hFF;
                4'b1101: f = a | ~b;
                4'b1110: f = a | b;
                default: f = a;
            endcase
        end else begin
            case (s)
                4'b1001: q = b;
                4'b0110: q = ~b;
                4'b1100: q = a;
                default: q = 8'h00;
            endcase
            sum = {1'b0, a} + {1'b0, q} + {8'h00, ~cn};
            f   = sum[7:0];
            co  = ~sum[8];
            ov  = (a[7] == q[7]) && (f[7] != a[7]);
        end
        return {ov, (f == 8'hFF), co, f};
    endfunction

    // Reference chained operation: returns {zero, overflow, a_eq_b, c_out, f[63:0]}.
    function automatic logic [67:0] chain(input logic [63:0] a, input logic [63:0] b, input int nb,
                                          input logic [3:0] s, input logic m, input logic cin);
        logic [63:0] f;
        logic [10:0] r;
        logic        c, eq, ov;
        f = '0; c = cin; eq = 1'b1; ov = 1'b0;
        for (int k = 0; k < nb; k++) begin
            r = alu181(a[8*k +: 8], b[8*k +: 8], s, m, (k == 0 || m) ? cin : c);
            f[8*k +: 8] = r[7:0];
            c  = r[8];
            eq = eq & r[9];
            ov = r[10];
        end
        return {(f == 64'd0), ov, eq, c, f};
    endfunction

    assign {alu_ov2, alu_eq2, alu_co2, alu_f2} = alu181(alu_a2, alu_b2, alu_s2, alu_m2, alu_c_in2);
    assign {alu_ov1, alu_eq1, alu_co1, alu_f1} = alu181(alu_a1, alu_b1, alu_s1, alu_m1, alu_c_in1);

    ula_chain_sequencer #(.NBYTES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_a(cmd_a2), .cmd_b(cmd_b2), .cmd_s(cmd_s2), .cmd_m(cmd_m2), .cmd_c_in(cmd_c_in2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2), .alu_m(alu_m2), .alu_c_in(alu_c_in2),
        .alu_f(alu_f2), .alu_c_out(alu_co2), .alu_a_eq_b(alu_eq2), .alu_overflow(alu_ov2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_f(rsp_f2), .rsp_c_out(rsp_co2),
        .rsp_a_eq_b(rsp_eq2), .rsp_overflow(rsp_ov2), .rsp_zero(rsp_zero2)
    );

    ula_chain_sequencer #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_s(cmd_s1), .cmd_m(cmd_m1), .cmd_c_in(cmd_c_in1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_m(alu_m1), .alu_c_in(alu_c_in1),
        .alu_f(alu_f1), .alu_c_out(alu_co1), .alu_a_eq_b(alu_eq1), .alu_overflow(alu_ov1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_f(rsp_f1), .rsp_c_out(rsp_co1),
        .rsp_a_eq_b(rsp_eq1), .rsp_overflow(rsp_ov1), .rsp_zero(rsp_zero1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_rsp_valid2", rsp_valid2, 0);
        chk("rst_rsp2", {rsp_zero2, rsp_ov2, rsp_eq2, rsp_co2, rsp_f2}, 20'h80000);
        chk("rst_alu2", {alu_a2, alu_b2, alu_s2, alu_m2, alu_c_in2}, 0);
        chk("rst_rsp_valid1", rsp_valid1, 0);
        chk("rst_rsp1", {rsp_zero1, rsp_ov1, rsp_eq1, rsp_co1, rsp_f1}, 12'h800);
        chk("rst_alu1", {alu_a1, alu_b1, alu_s1, alu_m1, alu_c_in1}, 0);
        chk("rst_cmd_ready2", cmd_ready2, 0);
        chk("rst_cmd_ready1", cmd_ready1, 0);
    endtask

    // Drive a command in IDLE; returns one cycle into EXEC with cmd_* scrambled.
    task automatic start2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
        logic [67:0] r;
        r = chain({48'd0, a}, {48'd0, b}, 2, s, m, cin);
        exp_q2.push_back({r[67:64], r[15:0]});
        cmd_valid2 = 1'b1; cmd_a2 = a; cmd_b2 = b; cmd_s2 = s; cmd_m2 = m; cmd_c_in2 = cin;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready2, 1);
        tick();
        cmd_valid2 = 1'b0;
        cmd_a2 = 16'($urandom); cmd_b2 = 16'($urandom); cmd_s2 = 4'($urandom);
        cmd_m2 = ~m; cmd_c_in2 = ~cin;
    endtask

    task automatic exec2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin);
        logic [10:0] r0;
        r0 = alu181(a[7:0], b[7:0], s, m, cin);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("alu_a", alu_a2, (a >> (8 * i)) & 16'h00FF);
            chk("alu_b", alu_b2, (b >> (8 * i)) & 16'h00FF);
            chk("alu_s_m", {alu_s2, alu_m2}, {s, m});
            chk("alu_c_in", alu_c_in2, (i == 0 || m) ? cin : r0[8]);
            chk("exec_cmd_ready", cmd_ready2, 0);
            chk("exec_rsp_valid", rsp_valid2, 0);
            tick();
        end
    endtask

    // hold = cycles rsp_ready stays low; a stray cmd_valid is driven during the wait.
    task automatic finish2(input int hold);
        logic [19:0] e;
        e = exp_q2.pop_front();
        rsp_ready2 = 1'b0;
        for (int j = 0; j <= hold; j++) begin
            if (j == hold) rsp_ready2 = 1'b1;
            @(negedge clk);
            chk("rsp_valid", rsp_valid2, 1);
            chk("rsp_fields", {rsp_zero2, rsp_ov2, rsp_eq2, rsp_co2, rsp_f2}, e);
            chk("rsp_cmd_ready", cmd_ready2, 0);
            tick();
            cmd_valid2 = (j + 1 < hold);
        end
        rsp_ready2 = 1'b0;
        @(negedge clk);
        chk("rsp_dropped", rsp_valid2, 0);
        chk("cmd_ready_back", cmd_ready2, 1);
        tick();
    endtask

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input int hold);
        start2(a, b, s, m, cin);
        exec2(a, b, s, m, cin);
        finish2(hold);
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                        input logic m, input logic cin);
        logic [67:0] r;
        logic [11:0] e;
        r = chain({56'd0, a}, {56'd0, b}, 1, s, m, cin);
        exp_q1.push_back({r[67:64], r[7:0]});
        cmd_valid1 = 1'b1; cmd_a1 = a; cmd_b1 = b; cmd_s1 = s; cmd_m1 = m; cmd_c_in1 = cin;
        @(negedge clk);
        chk("n1_cmd_ready", cmd_ready1, 1);
        tick();
        cmd_valid1 = 1'b0;
        @(negedge clk);
        chk("n1_alu", {alu_a1, alu_b1, alu_c_in1}, {a, b, cin});
        chk("n1_exec_rsp_valid", rsp_valid1, 0);
        tick();
        e = exp_q1.pop_front();
        @(negedge clk);
        chk("n1_rsp_valid", rsp_valid1, 1);
        chk("n1_rsp_fields", {rsp_zero1, rsp_ov1, rsp_eq1, rsp_co1, rsp_f1}, e);
        tick();
        @(negedge clk);
        chk("n1_rsp_dropped", rsp_valid1, 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid2 = 1'b0; cmd_a2 = '0; cmd_b2 = '0; cmd_s2 = '0; cmd_m2 = 1'b0; cmd_c_in2 = 1'b0;
        cmd_valid1 = 1'b0; cmd_a1 = '0; cmd_b1 = '0; cmd_s1 = '0; cmd_m1 = 1'b0; cmd_c_in1 = 1'b0;
        rsp_ready2 = 1'b0;
        rsp_ready1 = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk_reset_values();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready2, 1);
        tick();

        // Add with carry across bytes (cin=1 is the no-carry level)
        run2(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0);
        // XOR in logic mode, nonzero and zero results
        run2(16'hA5F0, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 0);
        run2(16'h3C3C, 16'h3C3C, 4'b0110, 1'b1, 1'b1, 0);
        // Compare/subtract: equal, then mismatch only in the low slice under backpressure
        run2(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 0);
        run2(16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 5);
        // Signed overflow out of the top slice
        run2(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0);
        for (int n = 0; n < 4; n++) begin
            run2(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Reset during EXEC slice 0 discards the operation
        start2(16'hBEEF, 16'h1111, 4'b1001, 1'b0, 1'b1);
        void'(exp_q2.pop_back());
        rst_n = 1'b0;
        @(negedge clk);
        chk("cmd_ready_forced_low", cmd_ready1, 0);
        tick();
        @(negedge clk);
        chk_reset_values();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_abort", cmd_ready2, 1);
        for (int n = 0; n < 5; n++) begin
            tick();
            @(negedge clk);
            chk("no_rsp_after_abort", rsp_valid2, 0);
        end
        tick();
        run2(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 1);

        // Single-byte instance
        run1(8'h7F, 8'h01, 4'b1001, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            run1(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
